// File: rtl/rom_link_server_if.sv
// Byte-FIFO and ROM bus seen by the remote ROM link server.
// The master side is the server; the slave side is the FIFOs plus the ROM.
interface rom_link_server_if #(
   parameter int ROM_AW = 12
);
   logic              cmd_empty;
   logic              cmd_rd_en;
   logic [7:0]        cmd_dout;
   logic              rsp_full;
   logic              rsp_wr_en;
   logic [7:0]        rsp_din;
   logic              rom_en;
   logic [ROM_AW-4:0] rom_addr;
   logic [63:0]       rom_rdata;

   modport master (
      input  cmd_empty, cmd_dout, rsp_full, rom_rdata,
      output cmd_rd_en, rsp_wr_en, rsp_din, rom_en, rom_addr
   );

   modport slave (
      output cmd_empty, cmd_dout, rsp_full, rom_rdata,
      input  cmd_rd_en, rsp_wr_en, rsp_din, rom_en, rom_addr
   );
endinterface

// File: rtl/rom_link_server.sv
// Far-end server of the remote ROM byte link: pops an 8-byte address, reads one
// ROM word (or a fill pattern when out of range) and pushes its 8 bytes back.
module rom_link_server #(
   parameter int          ROM_AW   = 12,
   parameter logic [63:0] OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
   input  logic              clk,
   input  logic              rst_n,
   rom_link_server_if.master bus,
   output logic              busy,
   output logic              oor
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ROM_RD,
      S_ROM_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_icnt;
   logic [3:0]  r_ccnt;
   logic [3:0]  r_ocnt;
   logic        r_cap;
   // Byte offset bits are never stored: every ROM read is word aligned.
   logic [63:3] r_addr;
   logic [63:0] r_data;

   logic w_cmd_rd_en;
   logic w_rsp_wr_en;
   logic w_in_range;

   assign w_in_range  = (r_addr[63:ROM_AW] == '0);
   assign w_cmd_rd_en = (r_state == S_ADDR) && (r_icnt < 4'd8) && !bus.cmd_empty;
   assign w_rsp_wr_en = (r_state == S_RESP) && !bus.rsp_full;

   assign bus.cmd_rd_en = w_cmd_rd_en;
   assign bus.rsp_wr_en = w_rsp_wr_en;
   assign bus.rsp_din   = r_data[7:0];
   assign bus.rom_en    = (r_state == S_ROM_RD) && w_in_range;
   assign bus.rom_addr  = (r_state == S_ROM_RD) ? r_addr[ROM_AW-1:3] : '0;
   assign busy          = (r_state != S_IDLE);
   assign oor           = (r_state == S_ROM_RD) && !w_in_range;

   // NOTE: state is updated with non-blocking assignments so every branch below
   // sees the pre-edge values of the counters and shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_icnt  <= '0;
         r_ccnt  <= '0;
         r_ocnt  <= '0;
         r_cap   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!bus.cmd_empty) begin
                  r_state <= S_ADDR;
                  r_icnt  <= '0;
                  r_ccnt  <= '0;
                  r_cap   <= 1'b0;
               end
            end

            S_ADDR: begin
               if (w_cmd_rd_en) r_icnt <= r_icnt + 4'd1;
               // Standard FIFO: the popped byte appears on cmd_dout one cycle later.
               r_cap <= w_cmd_rd_en;
               if (r_cap) begin
                  r_addr <= {bus.cmd_dout, r_addr[63:11]};
                  r_ccnt <= r_ccnt + 4'd1;
                  if (r_ccnt == 4'd7) r_state <= S_ROM_RD;
               end
            end

            S_ROM_RD: begin
               r_ocnt <= '0;
               if (w_in_range) begin
                  r_state <= S_ROM_WAIT;
               end else begin
                  r_data  <= OOR_DATA;
                  r_state <= S_RESP;
               end
            end

            S_ROM_WAIT: begin
               r_data  <= bus.rom_rdata;
               r_state <= S_RESP;
            end

            S_RESP: begin
               if (w_rsp_wr_en) begin
                  r_data <= {8'h00, r_data[63:8]};
                  r_ocnt <= r_ocnt + 4'd1;
                  if (r_ocnt == 4'd7) r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_link_server.sv
// Randomized bench for rom_link_server: FIFO/ROM environment models plus a
// request-level reference model that predicts every response byte.
module tb_rom_link_server;
   localparam int          ROM_AW  = 12;
   localparam int          N_WORDS = 1 << (ROM_AW - 3);
   localparam logic [63:0] OOR     = 64'hDEAD_BEEF_DEAD_BEEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic oor;

   rom_link_server_if #(.ROM_AW(ROM_AW)) bus ();

   rom_link_server #(.ROM_AW(ROM_AW), .OOR_DATA(OOR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .oor   (oor)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Environment and model state.
   logic [63:0] rom [N_WORDS];
   logic [7:0]  cmd_q [$];
   logic [7:0]  rsp_q [$];
   logic [7:0]  exp_q [$];
   int          rom_obs_q [$];
   int          exp_rom_q [$];
   int          oor_obs = 0, exp_oor = 0;
   bit          pend_pop = 0, pend_rom = 0;
   int          pend_rom_addr = 0;
   int          pops_in_req = 0, resp_left = 0, gap_cnt = 0, full_cnt = 0;
   int          gap_after = 0, gap_len = 0, full_after = 0, full_len = 0;
   bit          rnd_stall = 0;
   int          viol_pop_empty = 0, viol_push_full = 0, viol_serial = 0, viol_extra = 0;
   int          cyc = 0, first_pop_cyc = 0, last_push_cyc = 0;

   always @(posedge clk) cyc++;

   function automatic logic [63:0] outs();
      return {42'd0, bus.cmd_rd_en, bus.rsp_wr_en, bus.rsp_din, bus.rom_en,
              bus.rom_addr, busy, oor};
   endfunction

   // FIFO/ROM models: inputs change at the falling edge, outputs sampled 1 unit later.
   always @(negedge clk) begin
      if (!rst_n) begin
         cmd_q.delete();
         rsp_q.delete();
         rom_obs_q.delete();
         oor_obs       = 0;
         pend_pop      = 0;
         pend_rom      = 0;
         pops_in_req   = 0;
         resp_left     = 0;
         gap_cnt       = 0;
         full_cnt      = 0;
         bus.cmd_empty = 1'b1;
         bus.rsp_full  = 1'b0;
         bus.cmd_dout  = 8'h00;
         bus.rom_rdata = 64'h0;
      end else begin
         if (pend_pop && cmd_q.size() != 0) bus.cmd_dout = cmd_q.pop_front();
         else bus.cmd_dout = 8'($urandom);
         if (pend_rom) bus.rom_rdata = rom[pend_rom_addr];
         else bus.rom_rdata = {$urandom, $urandom};
         bus.cmd_empty = (cmd_q.size() == 0) || (gap_cnt != 0) ||
                         (rnd_stall && $urandom_range(0, 2) == 0);
         if (gap_cnt != 0) gap_cnt--;
         bus.rsp_full = (full_cnt != 0) || (rnd_stall && $urandom_range(0, 2) == 0);
         if (full_cnt != 0) full_cnt--;
         #1;
         if (bus.cmd_rd_en) begin
            if (bus.cmd_empty) viol_pop_empty++;
            if (pops_in_req == 0 && resp_left != 0) viol_serial++;
            pops_in_req++;
            if (pops_in_req == 1) first_pop_cyc = cyc;
            if (pops_in_req == gap_after) gap_cnt = gap_len;
            if (pops_in_req == 8) begin
               pops_in_req = 0;
               resp_left   = 8;
            end
         end
         pend_pop = bus.cmd_rd_en;
         if (bus.rsp_wr_en) begin
            if (bus.rsp_full) viol_push_full++;
            if (resp_left == 0) viol_extra++;
            else begin
               resp_left--;
               if (8 - resp_left == full_after) full_cnt = full_len;
               if (resp_left == 0) last_push_cyc = cyc;
            end
            rsp_q.push_back(bus.rsp_din);
         end
         if (bus.rom_en) rom_obs_q.push_back(int'(bus.rom_addr));
         pend_rom      = bus.rom_en;
         pend_rom_addr = int'(bus.rom_addr);
         if (oor) oor_obs++;
      end
   end

   // Reference model: a request is 8 address bytes LSB first; the answer is the
   // addressed ROM word (or the fill word when above the ROM), LSB first.
   task automatic send(input logic [63:0] a);
      logic [63:0] word;
      for (int i = 0; i < 8; i++) cmd_q.push_back(8'((a >> (8 * i)) & 64'hFF));
      if ((a >> ROM_AW) != 0) begin
         word = OOR;
         exp_oor++;
      end else begin
         word = rom[int'((a % (64'd1 << ROM_AW)) / 8)];
         exp_rom_q.push_back(int'((a % (64'd1 << ROM_AW)) / 8));
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(8'((word >> (8 * i)) & 64'hFF));
   endtask

   task automatic drain(input int n, input string tag);
      int waited = 0;
      while (rsp_q.size() < n && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_done"}, 64'(rsp_q.size() >= n), 64'd1);
      repeat (4) @(negedge clk);
      #2;
      for (int i = 0; i < n; i++) begin
         if (rsp_q.size() == 0 || exp_q.size() == 0) break;
         check($sformatf("%s_byte%0d", tag, i), 64'(rsp_q.pop_front()), 64'(exp_q.pop_front()));
      end
      check({tag, "_extra_bytes"}, 64'(rsp_q.size()), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_cmd_left"}, 64'(cmd_q.size()), 64'd0);
      check({tag, "_rom_reads"}, 64'(rom_obs_q.size()), 64'(exp_rom_q.size()));
      while (rom_obs_q.size() != 0 && exp_rom_q.size() != 0)
         check({tag, "_rom_addr"}, 64'(rom_obs_q.pop_front()), 64'(exp_rom_q.pop_front()));
      rom_obs_q.delete();
      exp_rom_q.delete();
      check({tag, "_oor_pulses"}, 64'(oor_obs), 64'(exp_oor));
      check({tag, "_protocol"},
            64'(viol_pop_empty + viol_push_full + viol_serial + viol_extra), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      int          waited;
      logic [63:0] a;
      int          n_req;

      for (int i = 0; i < N_WORDS; i++) rom[i] = {$urandom, $urandom};
      rom[2] = 64'h1122_3344_5566_7788;
      rom[3] = 64'h0102_0304_0506_0708;

      repeat (2) @(negedge clk);
      #2 check("reset_outputs", outs(), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #2 check("idle_outputs", outs(), 64'd0);

      // Word 2, no stalls: also checks minimum latency.
      @(posedge clk);
      send(64'h10);
      drain(8, "t1_word2");
      check("t1_latency", 64'(last_push_cyc - first_pop_cyc + 1), 64'd19);

      // Out-of-range address answered with the fill word.
      @(posedge clk);
      send(64'hEFCD_AB89_6745_2301);
      drain(8, "t2_oor");

      // Command FIFO runs dry for 3 cycles after the 4th address byte.
      gap_after = 4;
      gap_len   = 3;
      @(posedge clk);
      send(64'h10);
      drain(8, "t3_cmd_gap");
      check("t3_latency", 64'(last_push_cyc - first_pop_cyc + 1), 64'd22);
      gap_after = 0;

      // Response FIFO full for 5 cycles after the 2nd pushed byte.
      full_after = 2;
      full_len   = 5;
      @(posedge clk);
      send(64'h10);
      drain(8, "t4_rsp_full");
      check("t4_latency", 64'(last_push_cyc - first_pop_cyc + 1), 64'd24);
      full_after = 0;

      // Two requests queued back to back.
      @(posedge clk);
      send(64'h10);
      send(64'h18);
      drain(16, "t5_back2back");

      // Reset in the middle of a response.
      @(posedge clk);
      send(64'h10);
      waited = 0;
      while (rsp_q.size() < 3 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      check("t6_reached_resp", 64'(rsp_q.size() >= 3), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("t6_outputs_in_reset", outs(), 64'd0);
      exp_q.delete();
      exp_rom_q.delete();
      exp_oor = 0;
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      send(64'h18);
      drain(8, "t6_after_reset");

      // Random addresses with random FIFO stalls, one or two requests at a time.
      rnd_stall = 1;
      for (int r = 0; r < 24; r++) begin
         n_req = $urandom_range(1, 2);
         @(posedge clk);
         for (int k = 0; k < n_req; k++) begin
            if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, (1 << ROM_AW) - 1));
            else a = {$urandom, $urandom};
            send(a);
         end
         drain(8 * n_req, $sformatf("rnd%0d", r));
      end
      rnd_stall = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
